// File: rtl/buzzer_tone_scheduler.sv
// buzzer_tone_scheduler
// Shares one buzzer PWM datapath between N tone requesters. Pending requests
// are arbitrated round-robin. The winner's pitch index is mapped to a PWM
// period, and its note is timed in prescaled ticks. A silent gap follows each
// note before the next request is served.
//
// Ports
//   Clk50M        system clock
//   Rst_n         asynchronous active-low reset
//   req[N]        per-requester request, held until its grant pulse
//   pitch[5N]     pitch index, requester i at [5i+4:5i]
//   dur[8N]       note length in ticks, requester i at [8i+7:8i]
//   stop          synchronous abort of the current note or gap
//   grant[N]      one-hot, one-cycle acknowledge
//   busy          state is not IDLE
//   done          one-cycle pulse on the last cycle of a normally completed note
//   cnt_en        PWM enable
//   counter_arr   PWM period
//   counter_ccr   PWM compare, counter_arr >> 1
//
// state | meaning
// IDLE  | waiting for a request; arbitrates every cycle
// PLAY  | note sounding (or a timed rest), counting dur ticks
// GAP   | enforced silence, counting GAP_TICKS ticks
module buzzer_tone_scheduler #(
  parameter int N         = 4,
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 2
) (
  input  logic           Clk50M,
  input  logic           Rst_n,
  input  logic [N-1:0]   req,
  input  logic [5*N-1:0] pitch,
  input  logic [8*N-1:0] dur,
  input  logic           stop,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           done,
  output logic           cnt_en,
  output logic [31:0]    counter_arr,
  output logic [31:0]    counter_ccr
);

  localparam int PTRW = (N > 1) ? $clog2(N) : 1;
  localparam int PREW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PREW-1:0] PRE_LAST = PREW'(TICK_DIV - 1);
  localparam logic [7:0]      GAP_LOAD = 8'(GAP_TICKS);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [PREW-1:0]   pre_q, pre_d;
  logic [7:0]        tick_q, tick_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              done_q, done_d;
  logic              cnt_en_q, cnt_en_d;
  logic [31:0]       arr_q, arr_d;

  logic              win_found;
  logic [PTRW-1:0]   win_idx;
  logic [4:0]        sel_pitch;
  logic [7:0]        sel_dur;

  function automatic logic [31:0] pitch_to_arr(input logic [4:0] idx);
    logic [31:0] arr;
    case (idx)
      5'd0:    arr = 32'd191130;
      5'd1:    arr = 32'd170241;
      5'd2:    arr = 32'd151698;
      5'd3:    arr = 32'd143183;
      5'd4:    arr = 32'd127550;
      5'd5:    arr = 32'd113635;
      5'd6:    arr = 32'd101234;
      5'd7:    arr = 32'd95546;
      5'd8:    arr = 32'd85134;
      5'd9:    arr = 32'd75837;
      5'd10:   arr = 32'd71581;
      5'd11:   arr = 32'd63775;
      5'd12:   arr = 32'd56817;
      5'd13:   arr = 32'd50617;
      5'd14:   arr = 32'd47823;
      5'd15:   arr = 32'd42563;
      5'd16:   arr = 32'd37921;
      5'd17:   arr = 32'd35793;
      5'd18:   arr = 32'd31887;
      5'd19:   arr = 32'd28408;
      5'd20:   arr = 32'd25309;
      default: arr = 32'd0;   // rest
    endcase
    return arr;
  endfunction

  // Round-robin search: first set req bit at or above the pointer, wrapping.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = PTRW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pre_d     = pre_q;
    tick_d    = tick_q;
    grant_d   = '0;
    done_d    = 1'b0;
    cnt_en_d  = cnt_en_q;
    arr_d     = arr_q;
    sel_pitch = pitch[5*int'(win_idx) +: 5];
    sel_dur   = dur[8*int'(win_idx) +: 8];

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          ptr_d = (int'(win_idx) == N-1) ? '0 : win_idx + 1'b1;
          pre_d = '0;
          if (sel_dur == 8'd0) begin
            // Zero-length note: acknowledge and complete at once, no PLAY.
            done_d   = 1'b1;
            cnt_en_d = 1'b0;
            tick_d   = GAP_LOAD;
            state_d  = (GAP_TICKS > 0) ? GAP : IDLE;
          end else begin
            state_d  = PLAY;
            tick_d   = sel_dur;
            arr_d    = pitch_to_arr(sel_pitch);
            cnt_en_d = (sel_pitch <= 5'd20);
          end
        end
      end
      PLAY, GAP: begin
        if (stop) begin
          state_d  = IDLE;
          cnt_en_d = 1'b0;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (tick_q == 8'd1) begin
            cnt_en_d = 1'b0;
            if (state_q == PLAY && GAP_TICKS > 0) begin
              state_d = GAP;
              tick_d  = GAP_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q - 8'd1;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // done is registered, so it is raised when the coming cycle is the
    // final cycle of PLAY (this also covers the grant cycle itself).
    if (state_d == PLAY && pre_d == PRE_LAST && tick_d == 8'd1) done_d = 1'b1;
  end

  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      pre_q    <= '0;
      tick_q   <= '0;
      grant_q  <= '0;
      done_q   <= 1'b0;
      cnt_en_q <= 1'b0;
      arr_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      cnt_en_q <= cnt_en_d;
      arr_q    <= arr_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign cnt_en      = cnt_en_q;
  assign counter_arr = arr_q;
  assign counter_ccr = {1'b0, arr_q[31:1]};

endmodule

// File: tb/tb_buzzer_tone_scheduler.sv
// Testbench for buzzer_tone_scheduler: directed scenarios plus randomized
// request batches, checked by a scoreboard fed from a reference model.
module tb_buzzer_tone_scheduler;

  localparam int N  = 4;
  localparam int TD = 10;
  localparam int GT = 2;

  localparam int TAB [0:20] = '{191130, 170241, 151698, 143183, 127550, 113635, 101234,
                                95546, 85134, 75837, 71581, 63775, 56817, 50617,
                                47823, 42563, 37921, 35793, 31887, 28408, 25309};

  logic           Clk50M = 1'b0;
  logic           Rst_n  = 1'b0;
  logic [N-1:0]   req    = '0;
  logic [5*N-1:0] pitch  = '0;
  logic [8*N-1:0] dur    = '0;
  logic           stop   = 1'b0;
  logic [N-1:0]   grant;
  logic           busy, done, cnt_en;
  logic [31:0]    counter_arr, counter_ccr;

  buzzer_tone_scheduler #(.N(N), .TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .Clk50M(Clk50M), .Rst_n(Rst_n), .req(req), .pitch(pitch), .dur(dur), .stop(stop),
    .grant(grant), .busy(busy), .done(done), .cnt_en(cnt_en),
    .counter_arr(counter_arr), .counter_ccr(counter_ccr)
  );

  always #10 Clk50M = ~Clk50M;

  typedef struct {
    logic [N-1:0] g;
    logic [31:0]  arr;
    int           cnt_hi;
    int           done_off;
    int           busy_len;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          m_ptr  = 0;
  logic [31:0] m_arr  = '0;
  bit          mon_en = 1'b1;

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] ref_arr(input int p);
    return (p <= 20) ? TAB[p] : 32'd0;
  endfunction

  // ---------------- monitor ----------------
  bit   active = 1'b0;
  exp_t cur;
  int   cyc, cnt_hi, done_off, done_cnt, busy_len;

  always @(negedge Clk50M) begin
    if (!mon_en || !Rst_n) begin
      active = 1'b0;
    end else begin
      if (active && (grant != '0 || !busy)) begin
        chk("cnt_en_cycles", cnt_hi, cur.cnt_hi);
        chk("done_offset", done_off, cur.done_off);
        chk("done_count", done_cnt, (cur.done_off >= 0) ? 1 : 0);
        chk("busy_cycles", busy_len, cur.busy_len);
        active = 1'b0;
      end
      if (grant != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant actual=%b required=none", grant);
        end else begin
          cur = sb.pop_front();
          chk("grant", grant, cur.g);
          chk("counter_arr", counter_arr, cur.arr);
          chk("counter_ccr", counter_ccr, cur.arr >> 1);
          active   = 1'b1;
          cyc      = 0;
          cnt_hi   = 0;
          done_off = -1;
          done_cnt = 0;
          busy_len = 0;
        end
      end
      if (active) begin
        cyc++;
        if (cnt_en) cnt_hi++;
        if (done) begin
          done_cnt++;
          done_off = cyc - 1;
        end
        if (busy) busy_len++;
      end else if (cnt_en || done) begin
        checks++;
        errors++;
        $display("FAIL idle_activity actual=cnt_en:%0b,done:%0b required=0", cnt_en, done);
      end
    end
  end

  // ---------------- model + driver ----------------
  // stop_k: index (in grant order) of the note to abort, -1 for none.
  task automatic run_batch(input logic [N-1:0] mask, input logic [4:0] p [N],
                           input logic [7:0] d [N], input int stop_k, input int stop_seed);
    logic [N-1:0] pend;
    int   w, k, len, s, se, dd, pp, dcyc, c;
    int   stop_s, gk, cyc_in, n, stop_at;
    bit   got_first;
    exp_t e;

    pend   = mask;
    k      = 0;
    stop_s = 0;
    while (pend != '0) begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (w < 0 && pend[c]) w = c;
      end
      m_ptr   = (w + 1) % N;
      pend[w] = 1'b0;
      dd      = int'(d[w]);
      pp      = int'(p[w]);
      len     = (dd == 0) ? GT*TD : (dd + GT)*TD;
      s       = 0;
      if (k == stop_k) begin
        s      = 1 + (stop_seed % len);
        stop_s = s;
      end
      se   = (s > 0) ? s : len;
      dcyc = (dd == 0) ? 1 : dd*TD;
      if (dd != 0) m_arr = ref_arr(pp);
      e.g        = N'(1) << w;
      e.arr      = m_arr;
      e.cnt_hi   = (dd == 0 || pp > 20) ? 0 : ((se < dd*TD) ? se : dd*TD);
      e.done_off = (dcyc <= se) ? dcyc - 1 : -1;
      e.busy_len = se;
      sb.push_back(e);
      k++;
    end

    for (int i = 0; i < N; i++) begin
      pitch[5*i +: 5] = p[i];
      dur[8*i +: 8]   = d[i];
    end
    req       = mask;
    gk        = -1;
    cyc_in    = 0;
    n         = 0;
    stop_at   = -1;
    got_first = 1'b0;
    while (1) begin
      @(negedge Clk50M);
      n++;
      stop = 1'b0;
      if (grant != '0) begin
        gk++;
        cyc_in = 1;
        if (!got_first) begin
          got_first = 1'b1;
          chk("first_grant_latency", n, 1);
        end
        if (stop_at >= 0) begin
          chk("stop_to_grant", n - stop_at, 2);
          stop_at = -1;
        end
        req = req & ~grant;
      end else if (cyc_in > 0) begin
        cyc_in++;
      end
      if (stop_s > 0 && gk == stop_k && cyc_in == stop_s) begin
        stop    = 1'b1;
        stop_at = n;
        cyc_in  = 0;
      end
      if (req == '0 && !busy && grant == '0 && !stop) break;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL batch_timeout actual=%0d cycles required=completion", n);
        req  = '0;
        stop = 1'b0;
        break;
      end
    end
  endtask

  logic [4:0]   pa [N];
  logic [7:0]   da [N];
  logic [N-1:0] mask;
  int           sk, n;

  initial begin
    repeat (3) @(negedge Clk50M);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_arr", counter_arr, 0);
    chk("rst_ccr", counter_ccr, 0);
    Rst_n = 1'b1;
    @(negedge Clk50M);

    // all four requesting, one tick each: order 0,1,2,3 then 0 again
    pa = '{5'd0, 5'd5, 5'd12, 5'd20};
    da = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_batch(4'b1111, pa, da, -1, 0);
    pa = '{5'd3, 5'd0, 5'd0, 5'd0};
    run_batch(4'b0001, pa, da, -1, 0);

    // pitch 7, three ticks on requester 1
    pa = '{5'd0, 5'd7, 5'd0, 5'd0};
    da = '{8'd0, 8'd3, 8'd0, 8'd0};
    run_batch(4'b0010, pa, da, -1, 0);

    // rest note
    pa = '{5'd0, 5'd0, 5'd25, 5'd0};
    da = '{8'd0, 8'd0, 8'd2, 8'd0};
    run_batch(4'b0100, pa, da, -1, 0);

    // zero duration
    pa = '{5'd0, 5'd0, 5'd0, 5'd3};
    da = '{8'd0, 8'd0, 8'd0, 8'd0};
    run_batch(4'b1000, pa, da, -1, 0);

    // stop at cycle 5 of a 50-cycle note with another request pending
    pa = '{5'd9, 5'd0, 5'd14, 5'd0};
    da = '{8'd5, 8'd0, 8'd5, 8'd0};
    run_batch(4'b0101, pa, da, 0, 4);

    for (int it = 0; it < 25; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        pa[i] = 5'($urandom_range(0, 31));
        da[i] = 8'($urandom_range(0, 4));
      end
      sk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N-1)) : -1;
      run_batch(mask, pa, da, sk, int'($urandom_range(0, 999)));
    end

    // asynchronous reset in the middle of a note
    repeat (2) @(negedge Clk50M);
    mon_en = 1'b0;
    pitch[14:10] = 5'd7;
    dur[23:16]   = 8'd5;
    req          = 4'b0100;
    n = 0;
    while (!cnt_en && n < 100) begin
      @(negedge Clk50M);
      n++;
    end
    chk("pre_reset_playing", cnt_en, 1);
    req = '0;
    repeat (3) @(negedge Clk50M);
    #3 Rst_n = 1'b0;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_cnt_en", cnt_en, 0);
    chk("async_rst_arr", counter_arr, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    m_ptr = 0;
    m_arr = '0;
    @(negedge Clk50M);
    mon_en = 1'b1;
    Rst_n  = 1'b1;
    pa = '{5'd0, 5'd12, 5'd0, 5'd20};
    da = '{8'd0, 8'd1, 8'd0, 8'd1};
    run_batch(4'b1010, pa, da, -1, 0);

    repeat (3) @(negedge Clk50M);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
